// File: rtl/game_sequencer_if.sv
// Keypad/card inputs and turn/score outputs of the game sequencer.
// The master side is the keypad/datapath environment; the slave side is the sequencer.
interface game_sequencer_if;
    logic [3:0] keypad_in;
    logic [1:0] card_color;
    logic [2:0] card_number;
    logic       rnd_en;
    logic       whose;
    logic [7:0] score1;
    logic [7:0] score2;
    logic [7:0] draw_cnt;
    logic       busy;
    logic       finish;
    logic [1:0] winner;

    modport master (
        output keypad_in, card_color, card_number,
        input  rnd_en, whose, score1, score2, draw_cnt, busy, finish, winner
    );

    modport slave (
        input  keypad_in, card_color, card_number,
        output rnd_en, whose, score1, score2, draw_cnt, busy, finish, winner
    );
endinterface

// File: rtl/game_sequencer.sv
// Two-player turn/score controller: accepts draw keys, pulses the random generator,
// waits for the card value, scores it and decides when the game ends.
module game_sequencer #(
    parameter int unsigned CARD_LAT  = 2,
    parameter int unsigned TARGET    = 21,
    parameter int unsigned MAX_DRAWS = 16
) (
    input logic             clk,
    input logic             rst,
    game_sequencer_if.slave bus
);
    typedef enum logic [2:0] {StWait, StHold, StScore, StCheck, StDone} state_e;

    localparam logic [3:0] KeyP1      = 4'b0011;
    localparam logic [3:0] KeyP2      = 4'b0001;
    localparam logic [3:0] KeyRestart = 4'b1111;
    localparam logic [3:0] LatLast    = 4'(CARD_LAT - 1);
    localparam logic [7:0] Target     = 8'(TARGET);
    localparam logic [7:0] MaxDraws   = 8'(MAX_DRAWS);

    state_e     state_q;
    logic [3:0] key_prev_q;
    logic [3:0] lat_cnt_q;
    logic       whose_q;
    logic       rnd_en_q;
    logic       busy_q;
    logic       finish_q;
    logic [7:0] score1_q;
    logic [7:0] score2_q;
    logic [7:0] draw_cnt_q;
    logic [1:0] winner_q;
    logic [1:0] last1_q;
    logic [1:0] last2_q;

    logic       key_edge;
    logic       draw_key;
    logic       restart_key;
    logic       card_valid;
    logic [7:0] act_score;
    logic [1:0] act_last;
    logic [4:0] add_val;
    logic [8:0] sum;
    logic [7:0] new_score;

    always_comb begin
        key_edge    = bus.keypad_in != key_prev_q;
        draw_key    = key_edge && (bus.keypad_in == (whose_q ? KeyP2 : KeyP1));
        restart_key = key_edge && (bus.keypad_in == KeyRestart);
        card_valid  = (bus.card_color != 2'd0) && (bus.card_number >= 3'd1)
                      && (bus.card_number <= 3'd5);
        act_score   = whose_q ? score2_q : score1_q;
        act_last    = whose_q ? last2_q : last1_q;
        add_val     = 5'd0;
        if (card_valid) begin
            // Repeating the previous colour doubles the card's value.
            if (bus.card_color == act_last) begin
                add_val = {1'b0, bus.card_number, 1'b0};
            end else begin
                add_val = {2'b00, bus.card_number};
            end
        end
        sum       = {1'b0, act_score} + {4'b0000, add_val};
        new_score = sum[8] ? 8'hFF : sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StWait;
            key_prev_q <= 4'd0;
            lat_cnt_q  <= 4'd0;
            whose_q    <= 1'b0;
            rnd_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            finish_q   <= 1'b0;
            score1_q   <= 8'd0;
            score2_q   <= 8'd0;
            draw_cnt_q <= 8'd0;
            winner_q   <= 2'b00;
            last1_q    <= 2'd0;
            last2_q    <= 2'd0;
        end else begin
            key_prev_q <= bus.keypad_in;
            unique case (state_q)
                StWait: begin
                    if (draw_key) begin
                        rnd_en_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        lat_cnt_q <= 4'd0;
                        state_q   <= StHold;
                    end
                end
                StHold: begin
                    rnd_en_q <= 1'b0;
                    if (lat_cnt_q == LatLast) begin
                        state_q <= StScore;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 4'd1;
                    end
                end
                StScore: begin
                    if (whose_q) begin
                        score2_q <= new_score;
                        if (card_valid) last2_q <= bus.card_color;
                    end else begin
                        score1_q <= new_score;
                        if (card_valid) last1_q <= bus.card_color;
                    end
                    draw_cnt_q <= draw_cnt_q + 8'd1;
                    state_q    <= StCheck;
                end
                StCheck: begin
                    busy_q <= 1'b0;
                    if (act_score >= Target) begin
                        winner_q <= whose_q ? 2'b10 : 2'b01;
                        finish_q <= 1'b1;
                        state_q  <= StDone;
                    end else if (draw_cnt_q == MaxDraws) begin
                        if (score1_q > score2_q) begin
                            winner_q <= 2'b01;
                        end else if (score2_q > score1_q) begin
                            winner_q <= 2'b10;
                        end else begin
                            winner_q <= 2'b11;
                        end
                        finish_q <= 1'b1;
                        state_q  <= StDone;
                    end else begin
                        whose_q <= ~whose_q;
                        state_q <= StWait;
                    end
                end
                StDone: begin
                    if (restart_key) begin
                        score1_q   <= 8'd0;
                        score2_q   <= 8'd0;
                        draw_cnt_q <= 8'd0;
                        last1_q    <= 2'd0;
                        last2_q    <= 2'd0;
                        winner_q   <= 2'b00;
                        finish_q   <= 1'b0;
                        whose_q    <= 1'b0;
                        state_q    <= StWait;
                    end
                end
                default: state_q <= StWait;
            endcase
        end
    end

    assign bus.rnd_en   = rnd_en_q;
    assign bus.whose    = whose_q;
    assign bus.score1   = score1_q;
    assign bus.score2   = score2_q;
    assign bus.draw_cnt = draw_cnt_q;
    assign bus.busy     = busy_q;
    assign bus.finish   = finish_q;
    assign bus.winner   = winner_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed turns plus random keys/cards against a rule-level
// model; a second instance with a two-draw limit covers the forced-end tie.
module tb_game_sequencer;
    localparam int CL = 2;

    logic       clk;
    logic       rst;
    logic [3:0] keypad;
    logic [1:0] card_color;
    logic [2:0] card_number;
    logic       sel;

    game_sequencer_if bus ();
    game_sequencer_if bus2 ();

    assign bus.keypad_in    = keypad;
    assign bus.card_color   = card_color;
    assign bus.card_number  = card_number;
    assign bus2.keypad_in   = keypad;
    assign bus2.card_color  = card_color;
    assign bus2.card_number = card_number;

    game_sequencer #(.CARD_LAT(CL), .TARGET(21), .MAX_DRAWS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    game_sequencer #(.CARD_LAT(CL), .TARGET(21), .MAX_DRAWS(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    logic       o_rnd_en, o_whose, o_busy, o_finish;
    logic [7:0] o_score1, o_score2, o_draw_cnt;
    logic [1:0] o_winner;
    assign o_rnd_en   = sel ? bus2.rnd_en   : bus.rnd_en;
    assign o_whose    = sel ? bus2.whose    : bus.whose;
    assign o_busy     = sel ? bus2.busy     : bus.busy;
    assign o_finish   = sel ? bus2.finish   : bus.finish;
    assign o_score1   = sel ? bus2.score1   : bus.score1;
    assign o_score2   = sel ? bus2.score2   : bus.score2;
    assign o_draw_cnt = sel ? bus2.draw_cnt : bus.draw_cnt;
    assign o_winner   = sel ? bus2.winner   : bus.winner;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Game state as the rules describe it, for whichever instance is selected.
    int m_s1, m_s2, m_l1, m_l2, m_whose, m_draws, m_max, m_winner, m_finish;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit valid_card(input int c, input int n);
        return (c >= 1) && (n >= 1) && (n <= 5);
    endfunction

    function automatic int scored(input int s, input int last, input int c, input int n);
        int t;
        if (!valid_card(c, n)) return s;
        t = s + ((c == last) ? 2 * n : n);
        return (t > 255) ? 255 : t;
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_l1 = 0; m_l2 = 0;
        m_whose = 0; m_draws = 0; m_winner = 0; m_finish = 0;
        m_max = sel ? 2 : 16;
    endtask

    task automatic garbage();
        card_color  = 2'($urandom_range(0, 3));
        card_number = 3'($urandom_range(0, 7));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        keypad = 4'd0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        check("rst_rnd_en", 32'(o_rnd_en), 0);
        check("rst_score1", 32'(o_score1), 0);
        check("rst_score2", 32'(o_score2), 0);
        check("rst_whose", 32'(o_whose), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_finish", 32'(o_finish), 0);
        check("rst_winner", 32'(o_winner), 0);
        check("rst_draws", 32'(o_draw_cnt), 0);
    endtask

    task automatic turn(input logic [3:0] key, input int c, input int n);
        bit acc;
        int act;
        acc = (m_finish == 0) && (key == ((m_whose != 0) ? 4'b0001 : 4'b0011));
        @(negedge clk);
        keypad = key;
        garbage();
        @(negedge clk);
        check("rnd_en_on_key", 32'(o_rnd_en), 32'(acc));
        keypad = 4'd0;
        if (!acc) begin
            check("busy_no_draw", 32'(o_busy), 0);
            check("draws_no_draw", 32'(o_draw_cnt), 32'(m_draws));
            return;
        end
        @(negedge clk);
        check("rnd_en_one_cycle", 32'(o_rnd_en), 0);
        check("busy_in_turn", 32'(o_busy), 1);
        repeat (CL - 1) @(negedge clk);
        check("score1_before_sample", 32'(o_score1), 32'(m_s1));
        check("score2_before_sample", 32'(o_score2), 32'(m_s2));
        card_color  = 2'(c);
        card_number = 3'(n);
        if (m_whose == 0) begin
            m_s1 = scored(m_s1, m_l1, c, n);
            if (valid_card(c, n)) m_l1 = c;
        end else begin
            m_s2 = scored(m_s2, m_l2, c, n);
            if (valid_card(c, n)) m_l2 = c;
        end
        m_draws++;
        @(negedge clk);
        garbage();
        check("score1", 32'(o_score1), 32'(m_s1));
        check("score2", 32'(o_score2), 32'(m_s2));
        check("draw_cnt", 32'(o_draw_cnt), 32'(m_draws));
        check("whose_held", 32'(o_whose), 32'(m_whose));
        act = (m_whose != 0) ? m_s2 : m_s1;
        if (act >= 21) begin
            m_finish = 1;
            m_winner = (m_whose != 0) ? 2 : 1;
        end else if (m_draws == m_max) begin
            m_finish = 1;
            m_winner = (m_s1 > m_s2) ? 1 : ((m_s2 > m_s1) ? 2 : 3);
        end else begin
            m_whose = 1 - m_whose;
        end
        @(negedge clk);
        check("whose", 32'(o_whose), 32'(m_whose));
        check("finish", 32'(o_finish), 32'(m_finish));
        check("winner", 32'(o_winner), 32'(m_winner));
        check("busy_release", 32'(o_busy), 0);
    endtask

    task automatic restart();
        @(negedge clk);
        keypad = 4'b1111;
        garbage();
        @(negedge clk);
        keypad = 4'd0;
        if (m_finish != 0) begin
            m_s1 = 0; m_s2 = 0; m_l1 = 0; m_l2 = 0;
            m_whose = 0; m_draws = 0; m_winner = 0; m_finish = 0;
        end
        check("restart_rnd_en", 32'(o_rnd_en), 0);
        check("restart_finish", 32'(o_finish), 32'(m_finish));
        check("restart_winner", 32'(o_winner), 32'(m_winner));
        check("restart_score1", 32'(o_score1), 32'(m_s1));
        check("restart_score2", 32'(o_score2), 32'(m_s2));
        check("restart_draws", 32'(o_draw_cnt), 32'(m_draws));
        check("restart_whose", 32'(o_whose), 32'(m_whose));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        int r;
        sel = 1'b0;
        rst = 1'b0;
        keypad = 4'd0;
        card_color = 2'd0;
        card_number = 3'd0;
        repeat (2) @(negedge clk);
        do_reset();

        // First P1 draw: colour 1, number 3.
        turn(4'b0011, 1, 3);
        check("first_draw_score1", 32'(o_score1), 3);

        // Wrong-player key, repeated colour doubling, reaching the target, restart.
        do_reset();
        turn(4'b0001, 1, 1);
        turn(4'b0011, 2, 4);
        turn(4'b0001, 1, 1);
        turn(4'b0011, 2, 4);
        check("doubled_score1", 32'(o_score1), 12);
        turn(4'b0001, 3, 1);
        turn(4'b0011, 2, 5);
        check("target_winner", 32'(o_winner), 1);
        turn(4'b0011, 1, 5);
        turn(4'b0001, 1, 5);
        restart();
        check("after_restart_score1", 32'(o_score1), 0);

        // A key held for 20 cycles fires exactly once.
        do_reset();
        @(negedge clk);
        keypad = 4'b0011;
        card_color = 2'd3;
        card_number = 3'd2;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            pulses += int'(o_rnd_en);
        end
        keypad = 4'd0;
        m_s1 = scored(0, 0, 3, 2);
        m_l1 = 3;
        m_draws = 1;
        m_whose = 1;
        check("held_key_pulses", 32'(pulses), 1);
        check("held_key_score1", 32'(o_score1), 32'(m_s1));
        check("held_key_draws", 32'(o_draw_cnt), 32'(m_draws));
        check("held_key_whose", 32'(o_whose), 32'(m_whose));

        // Reset while a card is pending must discard it.
        do_reset();
        @(negedge clk);
        keypad = 4'b0011;
        @(negedge clk);
        check("hold_rnd_en", 32'(o_rnd_en), 1);
        keypad = 4'd0;
        rst = 1'b0;
        @(negedge clk);
        check("hold_rst_rnd_en", 32'(o_rnd_en), 0);
        check("hold_rst_busy", 32'(o_busy), 0);
        check("hold_rst_score1", 32'(o_score1), 0);
        rst = 1'b1;
        card_color = 2'd1;
        card_number = 3'd5;
        repeat (6) @(negedge clk);
        check("hold_rst_no_late_score", 32'(o_score1), 0);
        check("hold_rst_no_late_draw", 32'(o_draw_cnt), 0);
        model_reset();
        turn(4'b0011, 2, 2);

        // Random keys and cards.
        for (int i = 0; i < 60; i++) begin
            if (m_finish != 0) begin
                restart();
            end else begin
                r = int'($urandom_range(0, 9));
                if (r <= 6) begin
                    turn((m_whose != 0) ? 4'b0001 : 4'b0011, int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 7)));
                end else if (r == 7) begin
                    turn((m_whose != 0) ? 4'b0011 : 4'b0001, 1, 1);
                end else if (r == 8) begin
                    restart();
                end else begin
                    turn(4'b0101, 1, 1);
                end
            end
        end

        // Two-draw limit with equal scores ends in a tie.
        sel = 1'b1;
        do_reset();
        turn(4'b0011, 1, 2);
        turn(4'b0001, 1, 2);
        check("limit_finish", 32'(o_finish), 1);
        check("limit_tie", 32'(o_winner), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
